display_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the board's 7-segment digit bank. It shares one hex nibble decoder across NUM_DIGITS digits. It captures a display value through a req/ack handshake, only at frame boundaries, so a frame never shows mixed old and new values. Each frame it drives one digit at a time: a guard (all-off) interval, then a show interval. Optionally it blanks leading zeros. It sits between the processor debug outputs (PC, ALU result) and the per-digit anodes plus the shared decoder input.

---
 rtl/display_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_display_scan_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller.
// Captures a display value via req/ack only at frame boundaries and scans one digit
// at a time. Each digit gets a guard (all-off) interval, then a show interval.
// Optional leading-zero blanking is evaluated on the captured shadow value.
module display_scan_ctrl #(
   parameter int NUM_DIGITS   = 8,
   parameter int REFRESH_DIV  = 50000,
   parameter int GUARD_CYCLES = 500,
   parameter int BLANK_ZEROS  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    load_req,
   output logic                    load_ack,
   output logic [3:0]              nibble,
   output logic                    blank,
   output logic [NUM_DIGITS-1:0]   digit_en_n,
   output logic                    frame_done
);

   localparam int MAX_CNT = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
   localparam int CW      = $clog2(MAX_CNT) + 1;
   localparam int IW      = $clog2(NUM_DIGITS);

   localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD_CYCLES == 0) ? 0 : GUARD_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      ST_OFF,
      ST_GUARD,
      ST_SHOW
   } state_t;

   // Every digit starts in GUARD, or goes straight to SHOW when there is no guard phase.
   localparam state_t DIGIT_START = (GUARD_CYCLES == 0) ? ST_SHOW : ST_GUARD;

   state_t                  state, state_nx;
   logic [IW-1:0]           idx, idx_nx;
   logic [CW-1:0]           cnt, cnt_nx;
   logic [4*NUM_DIGITS-1:0] shadow, shadow_nx;
   logic                    ack_nx, fd_nx;
   logic [NUM_DIGITS-1:0]   en_nx;
   logic [3:0]              nib_nx;
   logic                    blank_nx;

   // Next-state, counter, index and shadow-capture logic.
   always_comb begin
      state_nx  = state;
      idx_nx    = idx;
      cnt_nx    = cnt + 1'b1;
      shadow_nx = shadow;
      ack_nx    = 1'b0;
      fd_nx     = 1'b0;
      case (state)
         ST_OFF: begin
            cnt_nx = '0;
            if (load_req) begin
               shadow_nx = value;
               ack_nx    = 1'b1;
               idx_nx    = '0;
               state_nx  = DIGIT_START;
            end
         end
         ST_GUARD: begin
            if (cnt == GUARD_LAST) begin
               cnt_nx   = '0;
               state_nx = ST_SHOW;
            end
         end
         ST_SHOW: begin
            if (cnt == SHOW_LAST) begin
               cnt_nx   = '0;
               state_nx = DIGIT_START;
               if (idx == IDX_LAST) begin
                  idx_nx = '0;
                  fd_nx  = 1'b1;
                  if (load_req) begin
                     shadow_nx = value;
                     ack_nx    = 1'b1;
                  end
               end else begin
                  idx_nx = idx + 1'b1;
               end
            end
         end
         default: begin
            state_nx = ST_OFF;
            cnt_nx   = '0;
         end
      endcase
   end

   // Outputs are derived from the next-state values so that registering them keeps them
   // aligned with the state they describe.
   always_comb begin
      en_nx    = '1;
      nib_nx   = '0;
      blank_nx = 1'b1;
      if (state_nx == ST_SHOW) begin
         blank_nx = 1'b0;
         for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (IW'(i) == idx_nx) begin
               en_nx[i] = 1'b0;
               nib_nx   = shadow_nx[4*i +: 4];
               if (BLANK_ZEROS != 0 && i > 0)
                  blank_nx = ((shadow_nx >> (4*i)) == '0);
            end
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_OFF;
         idx        <= '0;
         cnt        <= '0;
         shadow     <= '0;
         digit_en_n <= '1;
         nibble     <= '0;
         blank      <= 1'b1;
         load_ack   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nx;
         idx        <= idx_nx;
         cnt        <= cnt_nx;
         shadow     <= shadow_nx;
         digit_en_n <= en_nx;
         nibble     <= nib_nx;
         blank      <= blank_nx;
         load_ack   <= ack_nx;
         frame_done <= fd_nx;
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: three instances (guarded/blanking, no blanking, no guard)
// share one stimulus and are compared against a frame-position reference model.
module tb_display_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] value = '0;
   logic        load_req = 1'b0;

   logic [3:0]  en_w  [3];
   logic [3:0]  nib_w [3];
   logic        blank_w [3];
   logic        ack_w [3];
   logic        fd_w [3];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   display_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(3), .GUARD_CYCLES(1), .BLANK_ZEROS(1)) u_a (
      .clk(clk), .rst_n(rst_n), .value(value), .load_req(load_req), .load_ack(ack_w[0]),
      .nibble(nib_w[0]), .blank(blank_w[0]), .digit_en_n(en_w[0]), .frame_done(fd_w[0]));
   display_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(3), .GUARD_CYCLES(1), .BLANK_ZEROS(0)) u_b (
      .clk(clk), .rst_n(rst_n), .value(value), .load_req(load_req), .load_ack(ack_w[1]),
      .nibble(nib_w[1]), .blank(blank_w[1]), .digit_en_n(en_w[1]), .frame_done(fd_w[1]));
   display_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(3), .GUARD_CYCLES(0), .BLANK_ZEROS(1)) u_c (
      .clk(clk), .rst_n(rst_n), .value(value), .load_req(load_req), .load_ack(ack_w[2]),
      .nibble(nib_w[2]), .blank(blank_w[2]), .digit_en_n(en_w[2]), .frame_done(fd_w[2]));

   // Reference model: position within the frame plus the captured value.
   int          run_m [3];
   int          t_m   [3];
   logic [15:0] sh_m  [3];
   logic        ack_m [3];
   logic        fd_m  [3];

   function automatic int g_of(int c);
      return (c == 2) ? 0 : 1;
   endfunction

   function automatic int b_of(int c);
      return (c == 1) ? 0 : 1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int c = 0; c < 3; c++) begin
         if (!rst_n) begin
            run_m[c] <= 0; t_m[c] <= 0; sh_m[c] <= '0; ack_m[c] <= 1'b0; fd_m[c] <= 1'b0;
         end else begin
            ack_m[c] <= 1'b0;
            fd_m[c]  <= 1'b0;
            if (run_m[c] == 0) begin
               if (load_req) begin
                  run_m[c] <= 1; t_m[c] <= 0; sh_m[c] <= value; ack_m[c] <= 1'b1;
               end
            end else if (t_m[c] == 4 * (g_of(c) + 3) - 1) begin
               t_m[c]  <= 0;
               fd_m[c] <= 1'b1;
               if (load_req) begin
                  sh_m[c] <= value; ack_m[c] <= 1'b1;
               end
            end else begin
               t_m[c] <= t_m[c] + 1;
            end
         end
      end
   end

   // Expected {digit_en_n, nibble, blank, load_ack, frame_done} for instance c.
   function automatic logic [10:0] exp_out(int c);
      int          p, d;
      logic        show, bl;
      logic [15:0] s;
      logic [3:0]  en;
      if (run_m[c] == 0) return {4'hF, 4'h0, 1'b1, 1'b0, 1'b0};
      p    = g_of(c) + 3;
      d    = t_m[c] / p;
      show = (t_m[c] % p) >= g_of(c);
      s    = sh_m[c] >> (4 * d);
      en   = show ? ~(4'b0001 << d) : 4'hF;
      bl   = !show || (b_of(c) == 1 && d > 0 && s == 16'h0);
      return {en, show ? s[3:0] : 4'h0, bl, ack_m[c], fd_m[c]};
   endfunction

   function automatic logic [10:0] obs(int c);
      return {en_w[c], nib_w[c], blank_w[c], ack_w[c], fd_w[c]};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; load_req = 1'b0; value = '0;
      repeat (3) @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (obs(c) !== 11'b1111_0000_1_0_0) begin
            errors++;
            $display("FAIL reset_values inst=%0d got=%b exp=%b", c, obs(c), 11'b1111_0000_1_0_0);
         end
      end
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs(c) !== exp_out(c) || en_w[c] !== 4'hF || blank_w[c] !== 1'b1 || fd_w[c] !== 1'b0) begin
               errors++;
               $display("FAIL idle_off inst=%0d cyc=%0d got=%b exp=%b", c, k, obs(c), exp_out(c));
            end
         end
      end
   endtask

   task automatic test_first_load();
      int nfd = 0;
      value = 16'h00A3; load_req = 1'b1;
      @(negedge clk);
      checks++;
      if (ack_w[0] !== 1'b1 || en_w[0] !== 4'hF) begin
         errors++;
         $display("FAIL first_ack got=%b/%h exp=1/f", ack_w[0], en_w[0]);
      end
      load_req = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         if (fd_w[0] === 1'b1) nfd++;
         for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs(c) !== exp_out(c)) begin
               errors++;
               $display("FAIL first_scan inst=%0d cyc=%0d got=%b exp=%b", c, k, obs(c), exp_out(c));
            end
         end
         if (k == 1 || k == 5 || k == 9) begin
            checks++;
            if ((k == 1 && {en_w[0], nib_w[0], blank_w[0]} !== {4'b1110, 4'h3, 1'b0}) ||
                (k == 5 && {en_w[0], nib_w[0], blank_w[0]} !== {4'b1101, 4'hA, 1'b0}) ||
                (k == 9 && {en_w[0], blank_w[0]} !== {4'b1011, 1'b1})) begin
               errors++;
               $display("FAIL first_digit cyc=%0d got en=%b nib=%h blank=%b", k, en_w[0], nib_w[0], blank_w[0]);
            end
         end
      end
      checks++;
      if (nfd != 2) begin
         errors++;
         $display("FAIL frame_period got=%0d pulses exp=2 in 32 cycles", nfd);
      end
   endtask

   task automatic test_zero_blank();
      bit acked = 0;
      value = 16'h0000; load_req = 1'b1;
      for (int k = 0; k < 40 && !acked; k++) begin
         @(negedge clk);
         for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs(c) !== exp_out(c)) begin
               errors++;
               $display("FAIL zero_wait inst=%0d got=%b exp=%b", c, obs(c), exp_out(c));
            end
         end
         if (ack_w[0] === 1'b1) acked = 1;
      end
      load_req = 1'b0;
      checks++;
      if (!acked) begin
         errors++;
         $display("FAIL zero_ack_timeout got=no ack exp=ack within 40 cycles");
      end
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs(c) !== exp_out(c)) begin
               errors++;
               $display("FAIL zero_scan inst=%0d got=%b exp=%b", c, obs(c), exp_out(c));
            end
         end
         checks++;
         if ((en_w[1] !== 4'hF && blank_w[1] !== 1'b0) ||
             (en_w[0] === 4'b1110 && {nib_w[0], blank_w[0]} !== 5'b0000_0) ||
             (en_w[0] !== 4'hF && en_w[0] !== 4'b1110 && blank_w[0] !== 1'b1)) begin
            errors++;
            $display("FAIL zero_blank_rule got a=%b/%b b=%b/%b", en_w[0], blank_w[0], en_w[1], blank_w[1]);
         end
      end
   endtask

   task automatic test_midframe_load();
      bit acked = 0;
      for (int k = 0; k < 40 && fd_w[0] !== 1'b1; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      value = 16'h1234; load_req = 1'b1;
      for (int k = 0; k < 40 && !acked; k++) begin
         @(negedge clk);
         for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs(c) !== exp_out(c)) begin
               errors++;
               $display("FAIL mid_wait inst=%0d got=%b exp=%b", c, obs(c), exp_out(c));
            end
         end
         if (ack_w[0] === 1'b1) begin
            acked = 1;
            checks++;
            if (fd_w[0] !== 1'b1) begin
               errors++;
               $display("FAIL mid_ack_with_frame got fd=%b exp=1", fd_w[0]);
            end
         end
      end
      load_req = 1'b0;
      checks++;
      if (!acked) begin
         errors++;
         $display("FAIL mid_ack_timeout got=no ack exp=ack within 40 cycles");
      end
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs(c) !== exp_out(c)) begin
               errors++;
               $display("FAIL mid_scan inst=%0d got=%b exp=%b", c, obs(c), exp_out(c));
            end
         end
         checks++;
         if ((en_w[0] === 4'b1110 && nib_w[0] !== 4'h4) || (en_w[0] === 4'b1101 && nib_w[0] !== 4'h3) ||
             (en_w[0] === 4'b1011 && nib_w[0] !== 4'h2) || (en_w[0] === 4'b0111 && nib_w[0] !== 4'h1)) begin
            errors++;
            $display("FAIL mid_new_digits got en=%b nib=%h exp nibbles 4,3,2,1", en_w[0], nib_w[0]);
         end
      end
   endtask

   task automatic test_withdraw();
      for (int k = 0; k < 40 && fd_w[0] !== 1'b1; k++) @(negedge clk);
      repeat (2) @(negedge clk);
      value = 16'hFFFF; load_req = 1'b1;
      for (int k = 0; k < 26; k++) begin
         @(negedge clk);
         if (k == 5) load_req = 1'b0;
         for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs(c) !== exp_out(c)) begin
               errors++;
               $display("FAIL withdraw inst=%0d cyc=%0d got=%b exp=%b", c, k, obs(c), exp_out(c));
            end
         end
         checks++;
         if (ack_w[0] !== 1'b0 || (en_w[0] === 4'b1110 && nib_w[0] !== 4'h4)) begin
            errors++;
            $display("FAIL withdraw_no_ack got ack=%b nib=%h exp ack=0 nib=4", ack_w[0], nib_w[0]);
         end
      end
   endtask

   task automatic test_no_guard();
      int len = 0;
      bit off_seen = 0;
      for (int k = 0; k < 40 && fd_w[2] !== 1'b1; k++) @(negedge clk);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         len++;
         if (en_w[2] === 4'hF) off_seen = 1;
         checks++;
         if (obs(2) !== exp_out(2)) begin
            errors++;
            $display("FAIL noguard_scan got=%b exp=%b", obs(2), exp_out(2));
         end
         if (fd_w[2] === 1'b1) break;
      end
      checks++;
      if (len != 12 || off_seen) begin
         errors++;
         $display("FAIL noguard_frame got len=%0d off=%0d exp len=12 off=0", len, off_seen);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs(c) !== exp_out(c)) begin
               errors++;
               $display("FAIL random inst=%0d cyc=%0d got=%b exp=%b", c, k, obs(c), exp_out(c));
            end
         end
         value    = 16'($urandom);
         load_req = ($urandom_range(0, 3) == 0);
      end
      load_req = 1'b0;
   endtask

   task automatic test_reset_mid();
      load_req = 1'b0;
      for (int k = 0; k < 40 && en_w[0] !== 4'b1011; k++) @(negedge clk);
      checks++;
      if (en_w[0] !== 4'b1011) begin
         errors++;
         $display("FAIL rst_reach_digit2 got en=%b exp=1011", en_w[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if ({en_w[c], blank_w[c], ack_w[c], fd_w[c]} !== 7'b1111_1_0_0) begin
            errors++;
            $display("FAIL async_reset inst=%0d got=%b exp=1111100", c, {en_w[c], blank_w[c], ack_w[c], fd_w[c]});
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs(c) !== exp_out(c) || en_w[c] !== 4'hF) begin
               errors++;
               $display("FAIL post_reset_off inst=%0d got=%b exp=%b", c, obs(c), exp_out(c));
            end
         end
      end
      value = 16'h0005; load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({en_w[0], nib_w[0], blank_w[0]} !== {4'b1110, 4'h5, 1'b0}) begin
         errors++;
         $display("FAIL post_reset_reload got en=%b nib=%h blank=%b exp 1110/5/0", en_w[0], nib_w[0], blank_w[0]);
      end
   endtask

   initial begin
      test_reset();
      test_first_load();
      test_zero_blank();
      test_midframe_load();
      test_withdraw();
      test_no_guard();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
